// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic register chain between two processor stages.
// Carries a DATA_W-bit payload through STAGES slots using valid/ready flow
// control, a global stall and a per-slot flush mask. Slot 0 faces the
// producer and slot STAGES-1 drives the consumer.
// Build option: define PIPE_PERF_CNT_EN to implement the stall, bubble and
// flush counters. Without it the counter ports are tied to zero and no
// counter flops are built.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   in_valid/in_ready/in_data     producer handshake (in_ready is combinational)
//   out_valid/out_ready/out_data  consumer handshake (out_valid is combinational)
//   stall                         freezes every slot
//   flush_mask                    bit i kills the entry slot i would hold next cycle
//   stage_valid, occupancy        per-slot valid bits and their popcount
//   stall_cnt, bubble_cnt, flush_cnt  saturating performance counters
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        stall,
    input  logic [STAGES-1:0]           flush_mask,
    output logic [STAGES-1:0]           stage_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            bubble_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_pre;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] ld;
    logic [DATA_W-1:0] d_q  [STAGES];
    logic [DATA_W-1:0] up_d [STAGES];
    logic              rdy_acc;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_nxt;

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] x);
        logic [OCC_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            s = s + OCC_W'(x[i]);
        end
        return s;
    endfunction

    // Ready ripples from the consumer back to the producer; stall blocks every slot.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            rdy_acc = (!v_q[i] | rdy_acc) & !stall;
            rdy[i]  = rdy_acc;
        end
    end

    // Upstream source of each slot: the input port for slot 0, else the previous slot.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        for (int i = 0; i < int'(STAGES); i++) begin
            up_d[i] = in_data;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
    end

    // v_pre is the pre-flush next valid; flush then overrides it unconditionally.
    always_comb begin
        v_pre = v_q;
        ld    = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (rdy[i]) begin
                v_pre[i] = up_v[i];
                ld[i]    = up_v[i];
            end
        end
        v_nxt   = v_pre & ~flush_mask;
        occ_nxt = popcount(v_nxt);
    end

    // Slot registers; payload only loads on a live upstream entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q   <= v_nxt;
            occ_q <= occ_nxt;
            for (int i = 0; i < int'(STAGES); i++) begin
                if (ld[i]) begin
                    d_q[i] <= up_d[i];
                end
            end
        end
    end

    assign in_ready    = rdy[0] & !stall;
    assign out_valid   = v_q[STAGES-1] & !stall;
    assign out_data    = d_q[STAGES-1];
    assign stage_valid = v_q;
    assign occupancy   = occ_q;

`ifdef PIPE_PERF_CNT_EN
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [OCC_W-1:0] kill_pop;
    logic [SUM_W-1:0] flush_sum;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] flush_q;

    // Killed = would have been live next cycle but is masked off.
    assign kill_pop  = popcount(v_pre & flush_mask);
    assign flush_sum = {1'b0, flush_q} + SUM_W'(kill_pop);

    // Saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (out_ready && !v_q[STAGES-1] && !stall && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            flush_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with STAGES=2, DATA_W=32.
module tb_pipe_stage_chain;

    localparam int unsigned DW = 32;
    localparam int unsigned ST = 2;
    localparam int unsigned CW = 32;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          stall = 1'b0;
    logic [ST-1:0] flush_mask = '0;
    logic [ST-1:0] stage_valid;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_chain #(.DATA_W(DW), .STAGES(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush_mask(flush_mask),
        .stage_valid(stage_valid), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = 1'b0; flush_mask = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_tests++; if (stage_valid !== 2'b00) begin n_fail++; $display("FAIL rst_stage_valid: got %b expected %b", stage_valid, 2'b00); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d expected %0d", occupancy, 0); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected %b", out_valid, 1'b0); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h expected %h", out_data, 32'h0); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected %b", in_ready, 1'b1); end
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        n_tests++; if (bubble_cnt !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL bubble_cnt: got %0d expected %0d", bubble_cnt, (PERF ? 4 : 0)); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready0: got %b expected %b", in_ready, 1'b1); end
        tick();
        in_data = 32'h22;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: got %b expected %b", out_valid, 1'b0); end
        tick();
        in_data = 32'h33;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin n_fail++; $display("FAIL stream_out1: got v=%b %h expected v=1 %h", out_valid, out_data, 32'h11); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready1: got %b expected %b", in_ready, 1'b1); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin n_fail++; $display("FAIL stream_out2: got v=%b %h expected v=1 %h", out_valid, out_data, 32'h22); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin n_fail++; $display("FAIL stream_out3: got v=%b %h expected v=1 %h", out_valid, out_data, 32'h33); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b expected %b", out_valid, 1'b0); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        #1;
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, 2); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected %b", in_ready, 1'b0); end
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin n_fail++; $display("FAIL bp_head: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hA0); end
        tick();
        n_tests++; if (out_data !== 32'hA0 || occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold: got %h occ=%0d expected %h occ=2", out_data, occupancy, 32'hA0); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_pass: got %b expected %b", in_ready, 1'b1); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin n_fail++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hA1); end
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_no_bubble: got %0d expected %0d", occupancy, 2); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hA2) begin n_fail++; $display("FAIL bp_third: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hA2); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected %b", out_valid, 1'b0); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
        tick();
        in_data = 32'hD1;
        tick();
        in_data = 32'hD2;
        stall = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid: got %b expected %b", out_valid, 1'b0); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected %b", in_ready, 1'b0); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (stage_valid !== 2'b11 || out_data !== 32'hD0) begin n_fail++; $display("FAIL stall_frozen%0d: got %b %h expected 11 %h", k, stage_valid, out_data, 32'hD0); end
        end
        stall = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, (PERF ? 3 : 0)); end
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hD0) begin n_fail++; $display("FAIL stall_resume0: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hD0); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hD1) begin n_fail++; $display("FAIL stall_resume1: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hD1); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stall_done: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, stall_cnt, (PERF ? 3 : 0)); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB0;
        tick();
        in_data = 32'hB1;
        tick();
        in_data = 32'hB2; out_ready = 1'b1; flush_mask = 2'b11;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected %b", in_ready, 1'b1); end
        tick();
        flush_mask = 2'b00; in_valid = 1'b0;
        n_tests++; if (stage_valid !== 2'b00 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_all: got %b occ=%0d expected 00 occ=0", stage_valid, occupancy); end
        n_tests++; if (flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL flush_cnt_all: got %0d expected %0d", flush_cnt, (PERF ? 2 : 0)); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || stage_valid !== 2'b00) begin n_fail++; $display("FAIL flush_b2_dropped: got v=%b %b expected v=0 00", out_valid, stage_valid); end
    endtask

    task automatic test_partial_flush();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hC0;
        tick();
        in_data = 32'hC1; flush_mask = 2'b01;
        tick();
        flush_mask = 2'b00; in_valid = 1'b0;
        n_tests++; if (stage_valid !== 2'b10) begin n_fail++; $display("FAIL pflush_valid: got %b expected %b", stage_valid, 2'b10); end
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hC0) begin n_fail++; $display("FAIL pflush_survivor: got v=%b %h expected v=1 %h", out_valid, out_data, 32'hC0); end
        n_tests++; if (flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL pflush_cnt: got %0d expected %0d", flush_cnt, (PERF ? 1 : 0)); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || stage_valid !== 2'b00) begin n_fail++; $display("FAIL pflush_c1_killed: got v=%b %b expected v=0 00", out_valid, stage_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hE0;
        tick();
        in_data = 32'hE1;
        tick();
        in_valid = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0;
        #1;
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL arst_pre_occ: got %0d expected %0d", occupancy, 2); end
        n_tests++; if (stall_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL arst_pre_stall_cnt: got %0d expected %0d", stall_cnt, (PERF ? 1 : 0)); end
        #1;
        rst = 1'b1;
        #1;
        n_tests++; if (stage_valid !== 2'b00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_clear: got %b v=%b expected 00 v=0", stage_valid, out_valid); end
        n_tests++; if (occupancy !== 2'd0 || out_data !== 32'h0) begin n_fail++; $display("FAIL arst_occ_data: got occ=%0d %h expected occ=0 %h", occupancy, out_data, 32'h0); end
        n_tests++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_counters: got %0d %0d %0d expected 0 0 0", stall_cnt, bubble_cnt, flush_cnt); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_stall();
        test_flush();
        test_partial_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline-register chain replacing the fixed, handshake-less fetch/decode and decode/memory buffers between processor stages. It carries a DATA_W-bit payload through STAGES register slots with per-slot valid bits, valid/ready back-pressure, a global stall, and a per-slot flush mask for branch/jump/trap redirects. Slot 0 faces the producing stage. Slot STAGES-1 drives the consuming stage.

## Interface
Parameters:
- DATA_W, 96, payload width in bits (pc + inst + side-band control)
- STAGES, 2, number of register slots; legal range 1..8
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers in_data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  DATA_W  payload from producer
- out_valid  output  1  slot STAGES-1 holds a live entry and the chain is not stalled
- out_ready  input  1  consumer accepts out_data
- out_data  output  DATA_W  payload of slot STAGES-1
- stall  input  1  global freeze; no slot moves
- flush_mask  input  STAGES  bit i kills the entry slot i would hold after this edge
- stage_valid  output  STAGES  registered valid bit of each slot (hazard-unit visibility)
- occupancy  output  $clog2(STAGES+1)  popcount of stage_valid
- stall_cnt  output  CNT_W  cycles with stall=1
- bubble_cnt  output  CNT_W  cycles with out_ready=1, out_valid=0, stall=0
- flush_cnt  output  CNT_W  live entries killed by flush

## Operation
- Slot i has registers v[i] and d[i]. Define ready[STAGES] = out_ready. Define ready[i] = !v[i] | ready[i+1], gated by !stall.
- in_ready = ready[0] & !stall (combinational). out_valid = v[STAGES-1] & !stall. out_data = d[STAGES-1].
- Moves per edge, when stall=0:
  - Slot i loads from slot i-1, or from the input for i=0, when ready[i].
  - v[i] takes the upstream valid bit.
  - d[i] loads only if the upstream valid is 1. Otherwise d[i] holds its value.
- If slot i is not ready, v[i] and d[i] hold.
- When stall=1, all v and d hold. No input is accepted and no output is transferred.
- Flush: if flush_mask[i]=1, the next value of v[i] is 0, regardless of stall, incoming load, or hold.
  - An entry leaving slot i in the same cycle is unaffected. Its destination slot's mask applies instead.
  - d[i] may still load but is don't-care.
- Handshake:
  - The producer holds in_valid and in_data until in_ready.
  - The chain keeps out_data stable while out_valid=1 and out_ready=0.
  - A transfer occurs when valid, ready and !stall are all 1.
- flush_cnt adds the popcount of entries killed this cycle. A slot counts as killed if it would otherwise have held a live entry next cycle.
- All counters saturate at all-ones and never wrap.

## Timing
- Reset values (asynchronous): v=0, d=0, counters=0, stage_valid=0, occupancy=0, out_valid=0, out_data=0.
  - in_ready=1 as soon as rst deasserts, provided stall=0.
- Latency: an entry accepted at edge N appears on out_valid after edge N+STAGES-1. This holds with no stall, no back-pressure and no flush.
- Throughput: one entry per cycle with out_ready held at 1.
- Full chain with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational pass-through).
- Full chain with out_ready=1: an input is accepted in the same cycle the output is drained. No bubble is inserted.
- Simultaneous events, highest priority first: rst, then flush, then stall, then normal move.
- rst asserted mid-transfer discards all entries immediately, with no clock edge required.
- STAGES=1: the chain behaves as a single skid-free register. in_ready = (!v[0] | out_ready) & !stall.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cnt, bubble_cnt and flush_cnt are implemented as described.
- PIPE_PERF_CNT_EN undefined:
  - The counter ports remain present and are driven constant 0.
  - No counter flops are synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use STAGES=2 and DATA_W=32.
- Streaming: send 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data is 0x11, 0x22, 0x33 on cycles 2, 3, 4; in_ready stays 1.
- Back-pressure: fill with 0xA0 and 0xA1 while out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA0. Raise out_ready -> 0xA0 then 0xA1 are delivered, in order, with no loss.
- Stall: assert stall for 3 cycles with 2 entries in flight -> out_valid=0, in_ready=0, state frozen. On release, delivery resumes. stall_cnt=3.
- Flush: chain holds 0xB0 in slot 1 and 0xB1 in slot 0; apply flush_mask=2'b11 for one cycle with in_valid=1 and data 0xB2 -> next cycle stage_valid=00 and 0xB2 is dropped. flush_cnt=2.
- Partial flush: apply flush_mask=2'b01 while 0xC0 moves into slot 1 and 0xC1 arrives -> 0xC0 survives and 0xC1 is killed.
- Async reset: assert rst between edges with occupancy=2 -> stage_valid=0 and out_valid=0 immediately. Counters read 0 with PIPE_PERF_CNT_EN defined, and read constant 0 without it.
